// File: rtl/fpa_rr_scheduler_if.sv
// fpa_rr_scheduler_if: request/response bundle between compute clients and the shared-adder scheduler
interface fpa_rr_scheduler_if #(
    parameter int N_REQ = 4
);
    logic [N_REQ-1:0]    req_valid;
    logic [N_REQ-1:0]    req_sub;
    logic [32*N_REQ-1:0] req_opa;
    logic [32*N_REQ-1:0] req_opb;
    logic [N_REQ-1:0]    req_ready;
    logic                resp_valid;
    logic                resp_ready;
    logic [31:0]         resp_result;
    logic [N_REQ-1:0]    resp_grant;
    modport master (
        output req_valid, req_sub, req_opa, req_opb, resp_ready,
        input  req_ready, resp_valid, resp_result, resp_grant
    );
    modport slave (
        input  req_valid, req_sub, req_opa, req_opb, resp_ready,
        output req_ready, resp_valid, resp_result, resp_grant
    );
endinterface

// File: rtl/fpa_rr_scheduler.sv
// fpa_rr_scheduler: round-robin sharing of one combinational fp32 adder among N_REQ requesters
module fpa (
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] y
);
    logic        swap, sx, eff_sub, rnd, a_nan, b_nan, a_inf, b_inf;
    logic [7:0]  ex, ey, d;
    logic [26:0] mx, my, my_sh, mask, norm;
    logic [27:0] s;
    logic [4:0]  lz, sh;
    logic [8:0]  en;
    logic [31:0] x, z, packed_r;
    assign a_nan = (&a[30:23]) & (|a[22:0]);
    assign b_nan = (&b[30:23]) & (|b[22:0]);
    assign a_inf = (&a[30:23]) & ~(|a[22:0]);
    assign b_inf = (&b[30:23]) & ~(|b[22:0]);
    always_comb begin
        swap = a[30:0] < b[30:0];
        x = swap ? b : a;
        z = swap ? a : b;
        sx = x[31];
        eff_sub = x[31] ^ z[31];
        ex = x[30:23] == 8'd0 ? 8'd1 : x[30:23];
        ey = z[30:23] == 8'd0 ? 8'd1 : z[30:23];
        mx = {x[30:23] != 8'd0, x[22:0], 3'b000};
        my = {z[30:23] != 8'd0, z[22:0], 3'b000};
        d = ex - ey;
        mask = (27'd1 << d[4:0]) - 27'd1;
        my_sh = d > 8'd26 ? {26'd0, |my} : (my >> d) | {26'd0, |(my & mask)};
        s = eff_sub ? {1'b0, mx} - {1'b0, my_sh} : {1'b0, mx} + {1'b0, my_sh};
        lz = 5'd27;
        for (int i = 0; i < 27; i++) if (s[i]) lz = 5'(26 - i);
        // left shift stops at exponent 1 so tiny results fall into the denormal range
        sh = {3'd0, lz} < ex - 8'd1 ? lz : 5'(ex - 8'd1);
        norm = s[27] ? {s[27:2], |s[1:0]} : s[26:0] << sh;
        en = s[27] ? {1'b0, ex} + 9'd1 : (norm[26] ? {1'b0, ex} - {4'd0, sh} : 9'd0);
        rnd = norm[2] & (norm[3] | norm[1] | norm[0]);
        packed_r = {en, norm[25:3]} + {31'd0, rnd};
        if (a_nan || b_nan || (a_inf && b_inf && a[31] != b[31])) y = 32'h7FC0_0000;
        else if (a_inf) y = a;
        else if (b_inf) y = b;
        else if (s == 28'd0) y = {a[31] & b[31], 31'd0};
        else if (packed_r[31:23] >= 9'd255) y = {sx, 8'hFF, 23'd0};
        else y = {sx, packed_r[30:0]};
    end
endmodule

module fpa_rr_scheduler #(
    parameter int N_REQ = 4,
    parameter int CNT_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    fpa_rr_scheduler_if.slave bus,
    output logic              busy,
    output logic [CNT_W-1:0]  done_count
);
    localparam int PW = $clog2(N_REQ);
    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
    state_t           state_q, state_d;
    logic [PW-1:0]    rr_ptr_q, rr_ptr_d, win, idx;
    logic             found;
    logic [N_REQ-1:0] win_oh, grant_q, grant_d, resp_grant_q, resp_grant_d;
    logic [31:0]      op_a_q, op_a_d, op_b_q, op_b_d, sum, resp_result_q, resp_result_d;
    logic             resp_valid_q, resp_valid_d;
    logic [CNT_W-1:0] done_count_q, done_count_d;
    fpa u_fpa (.a(op_a_q), .b(op_b_q), .y(sum));
    always_comb begin
        win = '0;
        idx = '0;
        found = 1'b0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            idx = PW'((int'(rr_ptr_q) + k) % N_REQ);
            if (bus.req_valid[idx]) begin
                win = idx;
                found = 1'b1;
            end
        end
        win_oh = N_REQ'(1) << win;
    end
    always_comb begin
        state_d = state_q;
        rr_ptr_d = rr_ptr_q;
        op_a_d = op_a_q;
        op_b_d = op_b_q;
        grant_d = grant_q;
        resp_valid_d = resp_valid_q;
        resp_result_d = resp_result_q;
        resp_grant_d = resp_grant_q;
        done_count_d = done_count_q;
        bus.req_ready = '0;
        case (state_q)
            IDLE: if (found) begin
                bus.req_ready = rst_n ? win_oh : '0;
                op_a_d = bus.req_opa[32*win +: 32];
                op_b_d = bus.req_opb[32*win +: 32] ^ {bus.req_sub[win], 31'd0};
                grant_d = win_oh;
                rr_ptr_d = win == PW'(N_REQ - 1) ? '0 : win + 1'b1;
                state_d = EXEC;
            end
            EXEC: begin
                resp_result_d = sum;
                resp_grant_d = grant_q;
                resp_valid_d = 1'b1;
                state_d = RESP;
            end
            RESP: if (bus.resp_ready) begin
                resp_valid_d = 1'b0;
                done_count_d = done_count_q + 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            rr_ptr_q <= '0;
            op_a_q <= '0;
            op_b_q <= '0;
            grant_q <= '0;
            resp_valid_q <= 1'b0;
            resp_result_q <= '0;
            resp_grant_q <= '0;
            done_count_q <= '0;
        end else begin
            state_q <= state_d;
            rr_ptr_q <= rr_ptr_d;
            op_a_q <= op_a_d;
            op_b_q <= op_b_d;
            grant_q <= grant_d;
            resp_valid_q <= resp_valid_d;
            resp_result_q <= resp_result_d;
            resp_grant_q <= resp_grant_d;
            done_count_q <= done_count_d;
        end
    end
    assign bus.resp_valid = resp_valid_q;
    assign bus.resp_result = resp_result_q;
    assign bus.resp_grant = resp_grant_q;
    assign busy = state_q != IDLE;
    assign done_count = done_count_q;
endmodule
